// File: rtl/trace_player.sv
`default_nettype none
// ==========================================================================
// trace_player : fetches opcode words from a trace ROM and issues
//                tree-targeted push/pop commands.              Rev 1.0
// ==========================================================================
module trace_player #(
  parameter  int PTW            = 16,
  parameter  int MTW            = 2,
  parameter  int TREE_NUM       = 4,
  parameter  int IDLECYCLE      = 1024,
  parameter  int ROM_SIZE       = 16,
  parameter  int LOOP_COUNT     = 1,
  parameter  int SKIP_EMPTY_POP = 1,
  parameter  int CNT_W          = 16,
  localparam int DW             = MTW + PTW,
  localparam int TNB            = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
  localparam int IB             = (IDLECYCLE > 1) ? $clog2(IDLECYCLE) : 1,
  localparam int AW             = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1,
  localparam int FW             = TNB + PTW + DW,
  localparam int TW             = ((IB > FW) ? IB : FW) + 2
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_enable,
  input  logic [TW-1:0]    i_trace_data,
  input  logic             i_task_fifo_full,
  output logic             o_read,
  output logic [AW-1:0]    o_read_addr,
  output logic             o_push,
  output logic [TNB-1:0]   o_push_tree_id,
  output logic [PTW-1:0]   o_push_priority,
  output logic [DW-1:0]    o_push_data,
  output logic             o_pop,
  output logic [TNB-1:0]   o_pop_tree_id,
  output logic             o_finish,
  output logic [CNT_W-1:0] o_push_cnt,
  output logic [CNT_W-1:0] o_pop_cnt,
  output logic [CNT_W-1:0] o_pop_skip_cnt
);

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_END  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_DELAY  = 3'd3,
    S_ISSUE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d, read_addr_q;
  logic             read_q;
  logic [TW-1:0]    word_q;
  logic [IB-1:0]    cnt_q;
  logic [31:0]      loops_q;
  logic [CNT_W-1:0] occ_q [TREE_NUM];
  logic             push_q, pop_q, finish_q;
  logic [TNB-1:0]   push_tree_q, pop_tree_q;
  logic [PTW-1:0]   push_pri_q;
  logic [DW-1:0]    push_data_q;
  logic [CNT_W-1:0] push_cnt_q, pop_cnt_q, skip_cnt_q;

  logic [1:0]       in_op_d, op_d;
  logic [IB-1:0]    in_n_d;
  logic [TNB-1:0]   tree_d;
  logic [CNT_W-1:0] occ_sel_d;
  logic             step_d, eop_d, fire_d, more_d, wrap_d;

  assign in_op_d   = i_trace_data[TW-1 -: 2];
  assign in_n_d    = i_trace_data[IB-1:0];
  assign op_d      = word_q[TW-1 -: 2];
  assign tree_d    = word_q[TW-3 -: TNB];
  assign occ_sel_d = occ_q[tree_d];
  assign wrap_d    = (pc_q == AW'(ROM_SIZE - 1));
  assign more_d    = (LOOP_COUNT == 0) || (loops_q > 32'd1);

  // step_d: current word retired, advance pc; eop_d: pass boundary reached.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    step_d  = 1'b0;
    eop_d   = 1'b0;
    fire_d  = 1'b0;
    case (state_q)
      S_IDLE:   if (i_enable) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (in_op_d)
          OP_IDLE: begin
            if (in_n_d == '0) step_d = 1'b1;
            else              state_d = S_DELAY;
          end
          OP_END:  eop_d = 1'b1;
          default: state_d = S_ISSUE;
        endcase
      end
      S_DELAY:  if (cnt_q <= IB'(1)) step_d = 1'b1;
      S_ISSUE: begin
        if (!i_task_fifo_full) begin
          step_d = 1'b1;
          fire_d = 1'b1;
        end
      end
      default:  state_d = S_DONE;
    endcase
    if (step_d) begin
      if (wrap_d) begin
        eop_d = 1'b1;
      end else begin
        pc_d    = pc_q + AW'(1);
        state_d = i_enable ? S_FETCH : S_IDLE;
      end
    end
    if (eop_d) begin
      if (more_d) begin
        pc_d    = '0;
        state_d = i_enable ? S_FETCH : S_IDLE;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      read_q      <= 1'b0;
      read_addr_q <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      loops_q     <= 32'(LOOP_COUNT);
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      finish_q    <= 1'b0;
      push_tree_q <= '0;
      pop_tree_q  <= '0;
      push_pri_q  <= '0;
      push_data_q <= '0;
      push_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      skip_cnt_q  <= '0;
      for (int t = 0; t < TREE_NUM; t++) occ_q[t] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      read_q  <= (state_d == S_FETCH);
      if (state_d == S_FETCH) read_addr_q <= pc_d;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      if (state_d == S_DONE) finish_q <= 1'b1;
      if (state_q == S_DECODE) begin
        word_q <= i_trace_data;
        cnt_q  <= in_n_d;
      end else if (state_q == S_DELAY) begin
        cnt_q  <= cnt_q - IB'(1);
      end
      if (eop_d && more_d && (LOOP_COUNT != 0)) loops_q <= loops_q - 32'd1;
      if (fire_d) begin
        if (op_d == OP_PUSH) begin
          push_q      <= 1'b1;
          push_tree_q <= tree_d;
          push_pri_q  <= word_q[TW-3-TNB -: PTW];
          push_data_q <= word_q[TW-3-TNB-PTW -: DW];
          if (occ_sel_d != '1)  occ_q[tree_d] <= occ_sel_d + CNT_W'(1);
          if (push_cnt_q != '1) push_cnt_q <= push_cnt_q + CNT_W'(1);
        end else if ((occ_sel_d != '0) || (SKIP_EMPTY_POP == 0)) begin
          pop_q      <= 1'b1;
          pop_tree_q <= tree_d;
          if (occ_sel_d != '0) occ_q[tree_d] <= occ_sel_d - CNT_W'(1);
          if (pop_cnt_q != '1) pop_cnt_q <= pop_cnt_q + CNT_W'(1);
        end else begin
          if (skip_cnt_q != '1) skip_cnt_q <= skip_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign o_read          = read_q;
  assign o_read_addr     = read_addr_q;
  assign o_push          = push_q;
  assign o_push_tree_id  = push_tree_q;
  assign o_push_priority = push_pri_q;
  assign o_push_data     = push_data_q;
  assign o_pop           = pop_q;
  assign o_pop_tree_id   = pop_tree_q;
  assign o_finish        = finish_q;
  assign o_push_cnt      = push_cnt_q;
  assign o_pop_cnt       = pop_cnt_q;
  assign o_pop_skip_cnt  = skip_cnt_q;

endmodule
`default_nettype wire
